// File: rtl/stereolbm_axis_cambm_sdiv_15s_10ns_seq.sv
// Sequential signed-by-unsigned restoring divider.
// Takes a two's-complement dividend and a zero-extended unsigned divisor and
// produces a truncating quotient and remainder one quotient bit per cycle.
// Optional clock enable: define STEREOLBM_AXIS_CAMBM_SDIV_CE_EN to add port ce.
// When the port is added, ce=0 freezes every register and start is ignored.
// Without the macro the block behaves as if ce were permanently 1.
module stereolbm_axis_cambm_sdiv_15s_10ns_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 15,
    parameter int din1_WIDTH = 10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
    input  logic                  ce,
`endif
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] dividend0,
    input  logic [din1_WIDTH-1:0] divisor0,
    output logic                  ready,
    output logic                  done,
    output logic [din0_WIDTH-1:0] quotient,
    output logic [din1_WIDTH:0]   remainder
);

    // Partial remainder width, trial width and iteration counter width.
    localparam int RW = din1_WIDTH + 1;
    localparam int TW = RW + 1;
    localparam int CW = $clog2(din0_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ID is only an instance tag; no tag value produces any hardware.
    if (ID < 0) begin : g_id_tag_only
    end

    logic [1:0]            state_q,  state_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic                  neg_q,    neg_d;
    logic [din0_WIDTH-1:0] dq_q,     dq_d;
    logic [din1_WIDTH-1:0] div_q,    div_d;
    logic [RW-1:0]         rem_q,    rem_d;
    logic [din0_WIDTH-1:0] quot_q,   quot_d;
    logic [RW-1:0]         remo_q,   remo_d;

    logic                  ce_en;
    logic [TW-1:0]         trial;
    logic [TW-1:0]         div_ext;
    logic                  ge;
    logic [RW-1:0]         rem_step;
    logic [din0_WIDTH-1:0] dq_step;
    logic [din0_WIDTH-1:0] q_fin;
    logic [RW-1:0]         r_fin;
    logic [din0_WIDTH-1:0] abs_dividend;

`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
    assign ce_en = ce;
`else
    assign ce_en = 1'b1;
`endif

    // Magnitude of the dividend; the most negative value maps to 2^(W-1) exactly.
    assign abs_dividend = dividend0[din0_WIDTH-1] ? -dividend0 : dividend0;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial    = {rem_q, dq_q[din0_WIDTH-1]};
        div_ext  = {2'b00, div_q};
        ge       = (trial >= div_ext);
        rem_step = ge ? RW'(trial - div_ext) : RW'(trial);
        dq_step  = {dq_q[din0_WIDTH-2:0], ge};
    end

    // Sign fix-up of the final step, with saturation for a zero divisor.
    always_comb begin
        q_fin = neg_q ? -dq_step : dq_step;
        r_fin = neg_q ? -rem_step : rem_step;
        if (div_q == '0) begin
            q_fin = neg_q ? {1'b1, {(din0_WIDTH-1){1'b0}}}
                          : {1'b0, {(din0_WIDTH-1){1'b1}}};
            r_fin = '0;
        end
    end

    // Next-state logic: accept in IDLE, iterate in CALC, publish on DONE entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        dq_d    = dq_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        if (ce_en) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        neg_d   = dividend0[din0_WIDTH-1];
                        dq_d    = abs_dividend;
                        div_d   = divisor0;
                        rem_d   = '0;
                    end
                end
                S_CALC: begin
                    dq_d  = dq_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(din0_WIDTH - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        quot_d  = q_fin;
                        remo_d  = r_fin;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops any in-flight division.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            dq_q    <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            dq_q    <= dq_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_sdiv_15s_10ns_seq.sv
// Self-checking bench for the sequential signed divider.
// Expected results are queued when a division is launched and popped when
// done is seen; timing checks count cycles from the accepting edge.
module tb_stereolbm_axis_cambm_sdiv_15s_10ns_seq;

    typedef struct {
        logic [14:0] q;
        logic [10:0] r;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
    logic        ce;
`endif
    logic        start;
    logic [14:0] dividend0;
    logic [9:0]  divisor0;
    logic        ready;
    logic        done;
    logic [14:0] quotient;
    logic [10:0] remainder;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 ap_clk = ~ap_clk;

    stereolbm_axis_cambm_sdiv_15s_10ns_seq #(
        .ID(1),
        .din0_WIDTH(15),
        .din1_WIDTH(10)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
        .ce(ce),
`endif
        .start(start),
        .dividend0(dividend0),
        .divisor0(divisor0),
        .ready(ready),
        .done(done),
        .quotient(quotient),
        .remainder(remainder)
    );

    // Reference: truncating division, saturation on a zero divisor.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   qi;
        int   ri;
        if (b == 0) begin
            e.q = (a >= 0) ? 15'h3FFF : 15'h4000;
            e.r = 11'd0;
        end else begin
            qi  = a / b;
            ri  = a % b;
            e.q = qi[14:0];
            e.r = ri[10:0];
        end
        return e;
    endfunction

    // Called at a negedge with ready high; returns at the negedge after acceptance.
    task automatic launch(input int a, input int b, input exp_t e);
        sb.push_back(e);
        dividend0 = 15'(a);
        divisor0  = 10'(b);
        start     = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        start     = 1'b0;
    endtask

    // Counts negedges (first call cycle = 1) until done; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge ap_clk);
        end
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.q = 'x;
        e.r = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        start     = 1'b0;
        dividend0 = 15'd0;
        divisor0  = 10'd0;
        repeat (2) @(negedge ap_clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready: got %b want 1", ready);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_done: got %b want 0", done);
        end
        total++;
        if (quotient !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset_quotient: got %h want 0", quotient);
        end
        total++;
        if (remainder !== 11'd0) begin
            bad++;
            $display("[TB] FAIL reset_remainder: got %h want 0", remainder);
        end
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        total++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: got ready=%b done=%b want ready=1 done=0", ready, done);
        end
    endtask

    task automatic test_basic();
        int   ta[6] = '{100, -100, -16384, 16383, 0, -1};
        int   tb[6] = '{7, 7, 1, 1023, 5, 1023};
        int   tq[6] = '{14, -14, -16384, 16, 0, 0};
        int   tr[6] = '{2, -2, 0, 15, 0, -1};
        int   lat;
        exp_t e;
        exp_t g;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL basic_ready[%0d]: got %b want 1", i, ready);
            end
            e.q = 15'(tq[i]);
            e.r = 11'(tr[i]);
            launch(ta[i], tb[i], e);
            wait_done(lat);
            g = pop_exp();
            total++;
            if (lat !== 16) begin
                bad++;
                $display("[TB] FAIL basic_latency[%0d]: got %0d want 16", i, lat);
            end
            total++;
            if (quotient !== g.q) begin
                bad++;
                $display("[TB] FAIL basic_quotient[%0d]: got %0d want %0d", i, $signed(quotient), $signed(g.q));
            end
            total++;
            if (remainder !== g.r) begin
                bad++;
                $display("[TB] FAIL basic_remainder[%0d]: got %0d want %0d", i, $signed(remainder), $signed(g.r));
            end
            @(negedge ap_clk);
        end
        dividend0 = 15'h1234;
        divisor0  = 10'd3;
        repeat (5) @(negedge ap_clk);
        total++;
        if (quotient !== 15'd0 || remainder !== 11'h7FF) begin
            bad++;
            $display("[TB] FAIL hold_outputs: got q=%0d r=%0d want q=0 r=-1", $signed(quotient), $signed(remainder));
        end
    endtask

    task automatic test_div_zero();
        int   ta[2] = '{5, -5};
        int   tq[2] = '{16383, -16384};
        int   lat;
        exp_t e;
        exp_t g;
        for (int i = 0; i < 2; i++) begin
            e.q = 15'(tq[i]);
            e.r = 11'd0;
            launch(ta[i], 0, e);
            wait_done(lat);
            g = pop_exp();
            total++;
            if (lat !== 16) begin
                bad++;
                $display("[TB] FAIL divzero_latency[%0d]: got %0d want 16", i, lat);
            end
            total++;
            if (quotient !== g.q || remainder !== g.r) begin
                bad++;
                $display("[TB] FAIL divzero_result[%0d]: got q=%0d r=%0d want q=%0d r=%0d",
                         i, $signed(quotient), $signed(remainder), $signed(g.q), $signed(g.r));
            end
            @(negedge ap_clk);
        end
    endtask

    task automatic test_busy_start();
        int   lat;
        bit   extra;
        exp_t g;
        launch(100, 7, model(100, 7));
        repeat (4) @(negedge ap_clk);
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL busy_ready: got %b want 0", ready);
        end
        dividend0 = 15'd9;
        divisor0  = 10'd3;
        start     = 1'b1;
        @(negedge ap_clk);
        start     = 1'b0;
        wait_done(lat);
        g = pop_exp();
        total++;
        if (lat + 5 !== 16) begin
            bad++;
            $display("[TB] FAIL busy_latency: got %0d want 16", (lat < 0) ? lat : lat + 5);
        end
        total++;
        if (quotient !== g.q || remainder !== g.r) begin
            bad++;
            $display("[TB] FAIL busy_result: got q=%0d r=%0d want q=%0d r=%0d",
                     $signed(quotient), $signed(remainder), $signed(g.q), $signed(g.r));
        end
        @(negedge ap_clk);
        total++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL busy_after_done: got ready=%b done=%b want ready=1 done=0", ready, done);
        end
        extra = 1'b0;
        repeat (20) begin
            @(negedge ap_clk);
            if (done === 1'b1) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0 || quotient !== 15'd14) begin
            bad++;
            $display("[TB] FAIL busy_no_second: got extra_done=%b q=%0d want extra_done=0 q=14", extra, $signed(quotient));
        end
    endtask

    task automatic test_reset_midcalc();
        int   lat;
        bit   extra;
        exp_t g;
        launch(1000, 3, model(1000, 3));
        repeat (7) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        void'(pop_exp());
        total++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_ctrl: got ready=%b done=%b want ready=1 done=0", ready, done);
        end
        total++;
        if (quotient !== 15'd0 || remainder !== 11'd0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got q=%0d r=%0d want 0 0", $signed(quotient), $signed(remainder));
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        extra = 1'b0;
        repeat (20) begin
            @(negedge ap_clk);
            if (done === 1'b1) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_stale_done: got %b want 0", extra);
        end
        launch(50, 5, model(50, 5));
        wait_done(lat);
        g = pop_exp();
        total++;
        if (lat !== 16 || quotient !== g.q || remainder !== g.r) begin
            bad++;
            $display("[TB] FAIL midreset_fresh: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d",
                     lat, $signed(quotient), $signed(remainder), $signed(g.q), $signed(g.r));
        end
        @(negedge ap_clk);
    endtask

    task automatic test_back_to_back();
        int   a;
        int   b;
        int   lat;
        exp_t g;
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 32767)) - 16384;
            b = int'($urandom_range(0, 1023));
            total++;
            if (ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", i, ready);
            end
            launch(a, b, model(a, b));
            wait_done(lat);
            g = pop_exp();
            total++;
            if (lat !== 16 || quotient !== g.q || remainder !== g.r) begin
                bad++;
                $display("[TB] FAIL b2b[%0d] %0d/%0d: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d",
                         i, a, b, lat, $signed(quotient), $signed(remainder), $signed(g.q), $signed(g.r));
            end
            @(negedge ap_clk);
        end
    endtask

`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
    task automatic test_ce();
        int   lat;
        bit   seen;
        exp_t g;
        launch(100, 7, model(100, 7));
        repeat (4) @(negedge ap_clk);
        ce   = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge ap_clk);
            if (done === 1'b1) seen = 1'b1;
        end
        ce = 1'b1;
        wait_done(lat);
        g = pop_exp();
        total++;
        if (seen !== 1'b0 || lat + 8 !== 20) begin
            bad++;
            $display("[TB] FAIL ce_latency: got %0d early_done=%b want 20", (lat < 0) ? lat : lat + 8, seen);
        end
        total++;
        if (quotient !== g.q || remainder !== g.r) begin
            bad++;
            $display("[TB] FAIL ce_result: got q=%0d r=%0d want q=%0d r=%0d",
                     $signed(quotient), $signed(remainder), $signed(g.q), $signed(g.r));
        end
        @(negedge ap_clk);
    endtask
`endif

    initial begin
`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
        ce = 1'b1;
`endif
        test_reset();
        test_basic();
        test_div_zero();
        test_busy_start();
        test_reset_midcalc();
        test_back_to_back();
`ifdef STEREOLBM_AXIS_CAMBM_SDIV_CE_EN
        test_ce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stereolbm_axis_cambm_sdiv_15s_10ns_seq.md
STEREOLBM_AXIS_CAMBM_SDIV_15S_10NS_SEQ -- requirements
Module: stereolbm_axis_cambm_sdiv_15s_10ns_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 15, signed dividend width and quotient width.
REQ-003 SHALL have parameter din1_WIDTH, default 10, unsigned divisor width; remainder width is din1_WIDTH+1.
REQ-004 SHALL have port ap_clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port ce, input, 1, clock enable, present only per REQ-024.
REQ-007 SHALL have port start, input, 1, request pulse, sampled only while ready=1.
REQ-008 SHALL have port dividend0, input, din0_WIDTH, two's-complement dividend.
REQ-009 SHALL have port divisor0, input, din1_WIDTH, unsigned divisor, zero-extended.
REQ-010 SHALL have port ready, output, 1, high in IDLE only.
REQ-011 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-012 SHALL have port quotient, output, din0_WIDTH, signed quotient, held between results.
REQ-013 SHALL have port remainder, output, din1_WIDTH+1, signed remainder, held between results.

Function
REQ-014 SHALL implement FSM IDLE -> CALC (on start & ready) -> DONE (after din0_WIDTH CALC cycles) -> IDLE (next cycle); no other transitions.
REQ-015 SHALL latch dividend sign, |dividend0| (din0_WIDTH-bit unsigned; -2^(W-1) handled exactly) and divisor0 on the accepting edge.
REQ-016 SHALL perform restoring division, one quotient bit per CALC cycle, MSB first, using a din1_WIDTH+1-bit partial remainder.
REQ-017 SHALL truncate toward zero: quotient negated iff dividend negative; remainder takes dividend's sign; |remainder| < divisor.
REQ-018 SHALL assert done for exactly one cycle in DONE, quotient/remainder updated on the same edge, latency din0_WIDTH+1 cycles from accepting edge to done.
REQ-019 SHALL ignore start while ready=0 (CALC or DONE); no queuing; next accept earliest in the cycle after done.
REQ-020 SHALL, for divisor0=0, return quotient 2^(din0_WIDTH-1)-1 if dividend>=0 else -2^(din0_WIDTH-1), remainder 0, same latency.
REQ-021 SHALL not alter quotient/remainder except on the DONE entry edge.

Reset
REQ-022 SHALL on ap_rst_n=0 immediately force IDLE, ready=1, done=0, quotient=0, remainder=0, clear iteration counter, regardless of state.
REQ-023 SHALL discard any in-flight division on reset; no done pulse for it after release.

Configuration
REQ-024 SHALL, when macro STEREOLBM_AXIS_CAMBM_SDIV_CE_EN is defined, include port ce; ce=0 freezes all registers (FSM, counter, datapath, outputs, done held at current value); start ignored while ce=0.
REQ-025 SHALL, when STEREOLBM_AXIS_CAMBM_SDIV_CE_EN is undefined, omit port ce and behave as ce=1 permanently.

Verification
REQ-026 SHALL cover dividend 100, divisor 7 -> quotient 14, remainder 2, done 16 cycles after accept.
REQ-027 SHALL cover -100/7 -> -14, -2; and -16384/1 -> -16384, 0; and 16383/1023 -> 16, 15.
REQ-028 SHALL cover 5/0 -> 16383, 0 and -5/0 -> -16384, 0, latency 16.
REQ-029 SHALL cover start pulsed in CALC cycle 5 with 9/3 -> ignored; first result only, ready=1 the cycle after done.
REQ-030 SHALL cover ap_rst_n low in CALC cycle 8 -> outputs 0, ready=1, no done; fresh 50/5 after release -> 10, 0.
REQ-031 SHALL cover (CE_EN build) ce=0 for 4 cycles mid-CALC on 100/7 -> done at 20 cycles, result 14, 2.
